// File: rtl/spart_driver.sv
// spart_driver: minimal processor-side bus master for the SPART.
// Programs the baud divisor from br_cfg, then echoes every received byte.
module spart_driver #(
    parameter logic [15:0] DIV0 = 16'd650,
    parameter logic [15:0] DIV1 = 16'd325,
    parameter logic [15:0] DIV2 = 16'd162,
    parameter logic [15:0] DIV3 = 16'd80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic [7:0] echo_cnt
);

    typedef enum logic [2:0] {
        INIT_LO = 3'd0,
        INIT_HI = 3'd1,
        WAIT_RX = 3'd2,
        READ    = 3'd3,
        GAP     = 3'd4,
        WAIT_TX = 3'd5,
        WRITE   = 3'd6,
        GAP2    = 3'd7
    } state_e;

    localparam logic [1:0] ADDR_BUF   = 2'b00;
    localparam logic [1:0] ADDR_DB_LO = 2'b10;
    localparam logic [1:0] ADDR_DB_HI = 2'b11;

    state_e      state_q, state_d;
    logic [1:0]  cfg_q, cfg_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [7:0]  echo_cnt_q, echo_cnt_d;

    logic [15:0] div_sel;
    logic        cs_raw;
    logic        rw_raw;
    logic [1:0]  addr_raw;
    logic [7:0]  wdata;
    logic        drive;

    always_comb begin
        div_sel = DIV0;
        case (cfg_q)
            2'b00:   div_sel = DIV0;
            2'b01:   div_sel = DIV1;
            2'b10:   div_sel = DIV2;
            default: div_sel = DIV3;
        endcase
    end

    // cfg_q loads the live switch value while reset is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT_LO;
            cfg_q      <= br_cfg;
            rx_byte_q  <= 8'h00;
            echo_cnt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            rx_byte_q  <= rx_byte_d;
            echo_cnt_q <= echo_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        rx_byte_d  = rx_byte_q;
        echo_cnt_d = echo_cnt_q;
        case (state_q)
            INIT_LO: state_d = INIT_HI;
            INIT_HI: state_d = WAIT_RX;
            WAIT_RX: begin
                if (br_cfg != cfg_q) begin
                    cfg_d   = br_cfg;
                    state_d = INIT_LO;
                end else if (rda) begin
                    state_d = READ;
                end
            end
            READ: begin
                rx_byte_d = databus;
                state_d   = GAP;
            end
            GAP: state_d = WAIT_TX;
            WAIT_TX: begin
                if (tbr) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                echo_cnt_d = echo_cnt_q + 8'd1;
                state_d    = GAP2;
            end
            GAP2:    state_d = WAIT_RX;
            default: state_d = INIT_LO;
        endcase
    end

    always_comb begin
        cs_raw   = 1'b0;
        rw_raw   = 1'b1;
        addr_raw = ADDR_BUF;
        wdata    = 8'h00;
        case (state_q)
            INIT_LO: begin
                cs_raw   = 1'b1;
                rw_raw   = 1'b0;
                addr_raw = ADDR_DB_LO;
                wdata    = div_sel[7:0];
            end
            INIT_HI: begin
                cs_raw   = 1'b1;
                rw_raw   = 1'b0;
                addr_raw = ADDR_DB_HI;
                wdata    = div_sel[15:8];
            end
            READ: begin
                cs_raw   = 1'b1;
                rw_raw   = 1'b1;
                addr_raw = ADDR_BUF;
            end
            WRITE: begin
                cs_raw   = 1'b1;
                rw_raw   = 1'b0;
                addr_raw = ADDR_BUF;
                wdata    = rx_byte_q;
            end
            default: begin
                cs_raw   = 1'b0;
                rw_raw   = 1'b1;
                addr_raw = ADDR_BUF;
            end
        endcase
    end

    // Reset forces the bus idle without waiting for a clock edge
    assign iocs     = cs_raw & ~rst;
    assign iorw     = rw_raw | rst;
    assign ioaddr   = rst ? ADDR_BUF : addr_raw;
    assign drive    = iocs & ~iorw;
    assign databus  = drive ? wdata : 8'hzz;
    assign echo_cnt = echo_cnt_q;

endmodule

// File: doc/spart_driver.md
Name: spart_driver

Overview:
- Bus-master stage that sits directly upstream of the SPART, on the processor side of its iocs/iorw/ioaddr/databus interface.
- After reset it programs the SPART baud divisor from a 2-bit rate select.
- It then runs a polled echo loop: wait for rda, read the receive buffer, wait for tbr, write the same byte to the transmit buffer.
- Serves as the minimal "processor" for board bring-up and for SPART system tests.

Parameters:
- DIV0, 16'd650, divisor written when br_cfg=2'b00 (4800 baud at 50 MHz, 16x oversample)
- DIV1, 16'd325, divisor for br_cfg=2'b01 (9600)
- DIV2, 16'd162, divisor for br_cfg=2'b10 (19200)
- DIV3, 16'd80, divisor for br_cfg=2'b11 (38400)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- br_cfg  input  2  baud-rate select, from board switches; treated as quasi-static
- rda  input  1  SPART receive-data-available
- tbr  input  1  SPART transmit-buffer-ready
- iocs  output  1  chip select to SPART
- iorw  output  1  1 = read from SPART, 0 = write to SPART
- ioaddr  output  2  00 = rx/tx buffer, 10 = divisor low byte, 11 = divisor high byte
- databus  inout  8  shared SPART data bus; driven only on write cycles, high-Z otherwise
- echo_cnt  output  8  count of bytes echoed, wraps 255->0

Behaviour:
- Outputs are Moore outputs, decoded from the registered state.
- Idle bus value (every state not listed below): iocs=0, iorw=1, ioaddr=00, databus=Z.
- Reset (async): state=INIT_LO, cfg_q=br_cfg, rx_byte=8'h00, echo_cnt=0; bus outputs held at idle value while rst=1.
- States and transitions:
  - INIT_LO: iocs=1, iorw=0, ioaddr=10, databus=DIVn[7:0], with n=cfg_q. Next state INIT_HI.
  - INIT_HI: iocs=1, iorw=0, ioaddr=11, databus=DIVn[15:8]. Next state WAIT_RX.
  - WAIT_RX: idle bus.
    - If br_cfg != cfg_q: cfg_q<=br_cfg, next state INIT_LO (reprogram; takes priority over rda).
    - Else if rda=1: next state READ.
  - READ: iocs=1, iorw=1, ioaddr=00, databus=Z. rx_byte captured from databus on the clock edge that leaves READ. Next state GAP.
  - GAP: idle bus, one cycle; lets rda/tbr settle after the access. Next state WAIT_TX.
  - WAIT_TX: idle bus; go to WRITE when tbr=1. br_cfg changes are ignored here (a pending byte is never dropped).
  - WRITE: iocs=1, iorw=0, ioaddr=00, databus=rx_byte. echo_cnt<=echo_cnt+1 (8-bit wrap). Next state GAP2.
  - GAP2: idle bus, one cycle. Next state WAIT_RX; a br_cfg change is detected there on the following cycle.
- Cycle timing:
  - Divisor programming takes exactly 2 consecutive bus cycles, low byte first.
  - Minimum echo latency from rda sampled high to the WRITE cycle is 4 cycles (READ, GAP, WAIT_TX with tbr=1, WRITE).
- Bus rules:
  - databus is driven if and only if iocs=1 and iorw=0.
  - No two consecutive cycles are both bus accesses except INIT_LO->INIT_HI.
- rda held high continuously (back-to-back bytes): each byte costs one full loop. No read is issued while a byte is pending transmit.
- rst asserted mid-cycle (e.g. during WRITE): bus goes idle immediately and the pending byte is discarded. After release the first cycle is INIT_LO.
- Unused encodings of the state register recover to INIT_LO.

Test Plan:
- Reset release, br_cfg=01 -> cycle 1: iocs=1, iorw=0, ioaddr=10, databus=8'h45; cycle 2: ioaddr=11, databus=8'h01; then idle, databus=Z.
- In WAIT_RX, SPART model presents 8'hA5 with rda=1, tbr=1 -> READ cycle (iorw=1, ioaddr=00); 3 cycles later WRITE cycle with databus=8'hA5; echo_cnt=1.
- rda=1 with tbr=0 for 20 cycles, then tbr=1 -> driver stays in WAIT_TX with idle bus, issues exactly one WRITE of the captured byte one cycle after tbr rises, and no second READ.
- br_cfg changed 00->11 while in WAIT_RX -> next two cycles write 8'h50 to ioaddr 10, then 8'h00 to ioaddr 11. The same change made during WAIT_TX -> the pending byte is written first, then reprogramming.
- 256 echoed bytes -> echo_cnt wraps to 8'h00. Every write cycle shows databus driven; every read and idle cycle shows databus=Z (bus-contention check).
- rst pulsed during the WRITE cycle -> iocs=0 and databus=Z asynchronously. After release, the INIT_LO/INIT_HI sequence repeats with the current br_cfg.
